neural_layer_sequencer: RTL and testbench

Control sequencer for the 10-neuron dense-layer accumulator array. On a CPU start command it pulses the bias-load strobe, streams 13 packed pixel words (4 × 8-bit pixels each) from a valid/ready source into the core one word per accepted handshake, and waits a fixed drain interval. It then scans the neuron results for the arg-max class and raises done and irq. It sits between the accelerator register block / pixel FIFO and the neural core.

---
 rtl/neural_layer_sequencer_if.sv | 35 +++
 rtl/neural_layer_sequencer.sv | 157 +++++++++++++++
 tb/tb_neural_layer_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/neural_layer_sequencer_if.sv
// Pixel-stream and neural-core signal bundle around the layer sequencer.
// master = sequencer side; slave = pixel source / neural core side.
interface neural_layer_sequencer_if #(
    parameter int N_NEURONS = 10,
    parameter int W_PIXEL   = 32,
    parameter int W_RESULT  = 32
);
    logic                          pix_valid;
    logic [W_PIXEL-1:0]            pix_data;
    logic                          pix_ready;
    logic                          core_new_layer;
    logic                          core_pixel_ready;
    logic [W_PIXEL-1:0]            core_pixel_word;
    logic [N_NEURONS*W_RESULT-1:0] neurons_result;

    modport master (
        input  pix_valid,
        input  pix_data,
        input  neurons_result,
        output pix_ready,
        output core_new_layer,
        output core_pixel_ready,
        output core_pixel_word
    );

    modport slave (
        output pix_valid,
        output pix_data,
        output neurons_result,
        input  pix_ready,
        input  core_new_layer,
        input  core_pixel_ready,
        input  core_pixel_word
    );
endinterface

// File: rtl/neural_layer_sequencer.sv
// Dense-layer sequencer: bias strobe, pixel feed, drain, optional arg-max scan (NEURAL_SEQ_ARGMAX_EN).
// Latency start->done: 2+N_WORDS+DRAIN_CYCLES cycles, +N_NEURONS with arg-max, +1 per stalled feed cycle.
// Backpressure: pix_ready is held high through FEED; the feed stalls for as long as pix_valid is low.
module neural_layer_sequencer #(
    parameter int N_NEURONS    = 10,
    parameter int N_WORDS      = 13,
    parameter int W_PIXEL      = 32,
    parameter int W_RESULT     = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         irq_clr,
    neural_layer_sequencer_if.master     bus,
    output logic                         busy,
    output logic                         done,
    output logic                         irq,
    output logic [$clog2(N_NEURONS)-1:0] class_idx,
    output logic [W_RESULT-1:0]          class_score,
    output logic [$clog2(N_WORDS+1)-1:0] word_cnt
);
    localparam int IW = $clog2(N_NEURONS);
    localparam int CW = $clog2(N_WORDS+1);
    localparam int DW = $clog2(DRAIN_CYCLES+1);

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_FEED, S_DRAIN, S_ARGMAX, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic                accept, feed_last, drain_last, enter_done;
    logic [DW-1:0]       drain_cnt;
    logic [W_PIXEL-1:0]  pix_word_q;
    logic                pix_strobe_q;
    logic                pix_ready_c, new_layer_c, busy_c, done_c;

`ifdef NEURAL_SEQ_ARGMAX_EN
    logic [W_RESULT-1:0] result [N_NEURONS];
    logic [IW-1:0]       scan_idx, max_idx, best_idx;
    logic [W_RESULT-1:0] max_score, cur_score, best_score;
    logic                scan_last, take;
`else
    logic                unused_results;
`endif

    // Abort also cancels a handshake presented in the same cycle.
    assign accept     = (state == S_FEED) && bus.pix_valid && !abort;
    assign feed_last  = (word_cnt == CW'(N_WORDS-1));
    assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES-1));
    assign enter_done = (state_nxt == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pix_ready_c = 1'b0;
        new_layer_c = 1'b0;
        busy_c      = (state != S_IDLE);
        done_c      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_BIAS;
            S_BIAS: begin
                new_layer_c = 1'b1;
                state_nxt   = S_FEED;
            end
            S_FEED: begin
                pix_ready_c = 1'b1;
                if (accept && feed_last) state_nxt = S_DRAIN;
            end
`ifdef NEURAL_SEQ_ARGMAX_EN
            S_DRAIN:  if (drain_last) state_nxt = S_ARGMAX;
            S_ARGMAX: if (scan_last) state_nxt = S_DONE;
`else
            S_DRAIN:  if (drain_last) state_nxt = S_DONE;
`endif
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    assign bus.pix_ready        = pix_ready_c;
    assign bus.core_new_layer   = new_layer_c;
    assign bus.core_pixel_ready = pix_strobe_q;
    assign bus.core_pixel_word  = pix_word_q;
    assign busy                 = busy_c;
    assign done                 = done_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_word_q   <= '0;
            pix_strobe_q <= 1'b0;
            word_cnt     <= '0;
            drain_cnt    <= '0;
            irq          <= 1'b0;
        end else begin
            pix_strobe_q <= accept;
            if (accept) begin
                pix_word_q <= bus.pix_data;
                word_cnt   <= word_cnt + 1'b1;
            end else if (state == S_IDLE && start && !abort) begin
                word_cnt <= '0;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            // A completion in the same cycle as irq_clr must not be lost.
            if (enter_done)   irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end

`ifdef NEURAL_SEQ_ARGMAX_EN
    for (genvar g = 0; g < N_NEURONS; g++) begin : g_res
        assign result[g] = bus.neurons_result[g*W_RESULT +: W_RESULT];
    end

    assign cur_score  = result[scan_idx];
    assign scan_last  = (scan_idx == IW'(N_NEURONS-1));
    // Strict signed greater-than: ties keep the lower index already held.
    assign take       = (scan_idx == '0) || ($signed(cur_score) > $signed(max_score));
    assign best_idx   = take ? scan_idx  : max_idx;
    assign best_score = take ? cur_score : max_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx    <= '0;
            max_idx     <= '0;
            max_score   <= '0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            if (state == S_ARGMAX && !abort) begin
                scan_idx  <= scan_idx + 1'b1;
                max_idx   <= best_idx;
                max_score <= best_score;
            end else begin
                scan_idx <= '0;
            end
            if (enter_done) begin
                class_idx   <= best_idx;
                class_score <= best_score;
            end
        end
    end
`else
    assign class_idx      = '0;
    assign class_score    = '0;
    assign unused_results = ^bus.neurons_result;
`endif
endmodule

// File: tb/tb_neural_layer_sequencer.sv
// Directed bench for neural_layer_sequencer: pixel words scored through a queue, timing and results checked inline.
module tb_neural_layer_sequencer;
`ifdef NEURAL_SEQ_ARGMAX_EN
    localparam int AM      = 10;
    localparam int RST_REL = 20;
`else
    localparam int AM      = 0;
    localparam int RST_REL = 16;
`endif
    localparam int NW       = 13;
    localparam int EXP_DONE = 2 + NW + 2 + AM;

    logic        clk, rst, start, abort, irq_clr;
    logic        busy, done, irq;
    logic [3:0]  class_idx;
    logic [31:0] class_score;
    logic [3:0]  word_cnt;

    neural_layer_sequencer_if #(.N_NEURONS(10), .W_PIXEL(32), .W_RESULT(32)) bus ();

    neural_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .irq_clr(irq_clr),
        .bus(bus.master),
        .busy(busy), .done(done), .irq(irq),
        .class_idx(class_idx), .class_score(class_score), .word_cnt(word_cnt)
    );

    typedef struct { logic [31:0] w; int c; } exp_t;
    exp_t sb[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, t0 = 0, lay = 0;
    int nl_cnt = 0, px_cnt = 0, done_cnt = 0;
    int res_v [10];
    logic [3:0]  last_idx   = '0;
    logic [31:0] last_score = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pword(int k);
        return 32'h01020304 + 32'(k) * 32'h04040404 + 32'(lay) * 32'h10000000;
    endfunction

    // Scoreboard consumer: every core strobe must match the next queued word and cycle.
    always @(negedge clk) begin
        if (bus.core_pixel_ready === 1'b1) begin
            px_cnt++;
            if (sb.size() == 0) begin
                check("pixel_pulse_unexpected", 64'(cyc - t0), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pixel_word", bus.core_pixel_word, e.w);
                check("pixel_cycle", 64'(cyc - t0), 64'(e.c));
            end
        end
        if (bus.core_new_layer === 1'b1) begin
            nl_cnt++;
            check("new_layer_cycle", 64'(cyc - t0), 64'd1);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_idle(string p);
        check({p, "_busy"},        busy, 0);
        check({p, "_done"},        done, 0);
        check({p, "_irq"},         irq, 0);
        check({p, "_pix_ready"},   bus.pix_ready, 0);
        check({p, "_new_layer"},   bus.core_new_layer, 0);
        check({p, "_pixel_ready"}, bus.core_pixel_ready, 0);
        check({p, "_pixel_word"},  bus.core_pixel_word, 0);
        check({p, "_word_cnt"},    word_cnt, 0);
        check({p, "_class_idx"},   class_idx, 0);
        check({p, "_class_score"}, class_score, 0);
    endtask

    task automatic load_results();
        for (int i = 0; i < 10; i++) bus.neurons_result[i*32 +: 32] = res_v[i];
    endtask

    task automatic run_layer(int gap_at, int gap_len, int abort_after, int busy_start_rel,
                             int clr_rel, int rst_rel, logic [3:0] e_idx, logic [31:0] e_score);
        int k, rel, gap_left, nl0, px0, done0;
        bit got;
`ifndef NEURAL_SEQ_ARGMAX_EN
        e_idx = '0;
        e_score = '0;
`endif
        lay++;
        nl0 = nl_cnt; px0 = px_cnt; done0 = done_cnt;
        k = 0; gap_left = gap_len; got = 0;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        while (k < NW) begin
            rel = cyc - t0;
            if (rel > 100) begin
                check("feed_timeout", 0, 1);
                break;
            end
            start = (rel == busy_start_rel);
            if (k == abort_after) begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = pword(k);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0; bus.pix_valid = 1'b0; start = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_word_cnt", word_cnt, 64'(abort_after));
                repeat (EXP_DONE) @(negedge clk);
                check("abort_no_done", 64'(done_cnt), 64'(done0));
                check("abort_no_irq", irq, 0);
                check("abort_class_idx", class_idx, last_idx);
                check("abort_class_score", class_score, last_score);
                check("abort_px_pulses", 64'(px_cnt - px0), 64'(abort_after));
                return;
            end
            if (gap_left > 0 && k == gap_at && bus.pix_ready) begin
                bus.pix_valid = 1'b0;
                gap_left--;
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = pword(k);
                if (bus.pix_ready) begin
                    sb.push_back('{w: pword(k), c: 3 + k + ((k >= gap_at) ? gap_len : 0)});
                    k++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            rel = cyc - t0;
            irq_clr = (rel == clr_rel);
            if (rel == rst_rel) begin
                #2 rst = 1'b1;
                #1 check_idle("rst_mid");
                repeat (3) @(negedge clk);
                check("rst_new_layer_count", 64'(nl_cnt - nl0), 64'd1);
                check("rst_no_done", 64'(done_cnt), 64'(done0));
                rst = 1'b0;
                @(negedge clk);
                check_idle("rst_release");
                return;
            end
            if (done === 1'b1) got = 1;
            else @(negedge clk);
        end
        irq_clr = 1'b0;
        if (!got) begin
            check("done_seen", 0, 1);
            return;
        end
        check("done_cycle", 64'(cyc - t0), 64'(EXP_DONE + gap_len));
        check("class_idx", class_idx, e_idx);
        check("class_score", class_score, e_score);
        check("word_cnt", word_cnt, 64'(NW));
        check("irq_at_done", irq, 1);
        check("busy_at_done", busy, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("px_pulses", 64'(px_cnt - px0), 64'(NW));
        check("scoreboard_empty", 64'(sb.size()), 0);
        check("new_layer_count", 64'(nl_cnt - nl0), 64'd1);
        last_idx = e_idx;
        last_score = e_score;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; irq_clr = 1'b0;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.neurons_result = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // Ascending scores: winner is the last neuron.
        res_v = '{-10, -7, -4, -1, 2, 5, 8, 11, 14, 17};
        load_results();
        run_layer(99, 0, -1, -1, -1, -1, 4'd9, 32'd17);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", irq, 0);

        // Tie at 100 keeps index 2; 5-cycle stall after word 6; start while busy ignored.
        res_v = '{5, -3, 100, 7, 100, 0, -1, 2, 3, 4};
        load_results();
        run_layer(6, 5, -1, 5, -1, -1, 4'd2, 32'd100);

        // All equal negatives; irq_clr coincides with DONE entry while irq is still set.
        res_v = '{-8, -8, -8, -8, -8, -8, -8, -8, -8, -8};
        load_results();
        run_layer(99, 0, -1, -1, EXP_DONE - 1, -1, 4'd0, 32'hFFFF_FFF8);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared_2", irq, 0);

        // Abort after four words, then a clean layer.
        run_layer(99, 0, 4, -1, -1, -1, 4'd0, 32'd0);
        res_v = '{-10, -7, -4, -1, 2, 5, 8, 11, 14, 17};
        load_results();
        run_layer(99, 0, -1, -1, -1, -1, 4'd9, 32'd17);

        // Asynchronous reset in the middle of a layer.
        res_v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        load_results();
        run_layer(99, 0, -1, -1, -1, RST_REL, 4'd9, 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
